// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//    Hazard/stall sequencer for the pipelined MIPS core. Arbitrates between
//    data-memory wait, multi-cycle mult/div occupancy, taken-branch/jump
//    redirect and load-use hazards. It drives the PC hold and the
//    hold/flush/bubble controls of the IF/ID and ID/EX pipeline registers.
//
//    Build option: define STALL_PERF_EN to build the saturating stall-cycle
//    performance counter. When it is undefined, stall_cycles is tied to 0.
//
// Parameters
//    MD_CYCLES    total EX occupancy of a mult/div op (2 .. 2**CNT_W)
//    CNT_W        width of the mult/div down-counter
//
// Ports
//    clk          single clock, posedge
//    reset        synchronous, active-high
//    load_use     ID-stage load-use hazard detected
//    md_start     mult/div instruction present in EX
//    mem_req      MEM-stage load/store active
//    mem_ready    data memory completes the access this cycle
//    redirect     EX resolved a taken branch/jump
//    stop         PC hold
//    ifid_hold    IF/ID keeps its contents
//    ifid_flush   IF/ID loads a NOP
//    idex_bubble  ID/EX loads a NOP
//    pipe_freeze  ID/EX, EX/MEM and MEM/WB hold
//    md_busy      mult/div sequencing in progress
//    stall_cycles performance counter of cycles with stop = 1
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal issue; arbitrates mem wait > mult/div > redirect > load-use
// MEM_WAIT | frozen until mem_ready; the ready cycle itself is stall-free
// MD_WAIT  | mult/div in EX; frozen while counter != 0, counter 0 = release

module pipe_stall_ctrl #(
   parameter int MD_CYCLES = 32,
   parameter int CNT_W     = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_use,
   input  logic        md_start,
   input  logic        mem_req,
   input  logic        mem_ready,
   input  logic        redirect,
   output logic        stop,
   output logic        ifid_hold,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        pipe_freeze,
   output logic        md_busy,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MD_WAIT  = 2'd2
   } state_t;

   // The md_start cycle and the release cycle account for two of the
   // MD_CYCLES, so the counter only spans the frozen cycles in between.
   localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 2);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] md_cnt;
   logic [CNT_W-1:0] md_cnt_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      md_cnt_nxt  = md_cnt;
      stop        = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_freeze = 1'b0;
      md_busy     = 1'b0;

      case (state)
         RUN: begin
            // Lower-priority requests are dropped; the frozen upstream stages
            // keep presenting them, so they are seen again once back in RUN.
            if (mem_req && !mem_ready) begin
               stop        = 1'b1;
               ifid_hold   = 1'b1;
               pipe_freeze = 1'b1;
               state_nxt   = MEM_WAIT;
            end else if (md_start) begin
               stop        = 1'b1;
               ifid_hold   = 1'b1;
               pipe_freeze = 1'b1;
               md_cnt_nxt  = MD_LOAD;
               state_nxt   = MD_WAIT;
            end else if (redirect) begin
               // PC is free to load the branch target while both younger
               // slots are squashed.
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end else if (load_use) begin
               stop        = 1'b1;
               ifid_hold   = 1'b1;
               idex_bubble = 1'b1;
            end
         end

         MEM_WAIT: begin
            if (mem_ready) begin
               state_nxt = RUN;
            end else begin
               stop        = 1'b1;
               ifid_hold   = 1'b1;
               pipe_freeze = 1'b1;
            end
         end

         MD_WAIT: begin
            md_busy = 1'b1;
            if (md_cnt != '0) begin
               stop        = 1'b1;
               ifid_hold   = 1'b1;
               pipe_freeze = 1'b1;
               md_cnt_nxt  = md_cnt - CNT_W'(1);
            end else begin
               state_nxt = RUN;
            end
         end

         default: begin
            state_nxt  = RUN;
            md_cnt_nxt = '0;
         end
      endcase
   end

`ifdef STALL_PERF_EN
   logic [31:0] perf_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_cnt <= '0;
      end else if (stop && (perf_cnt != 32'hFFFF_FFFF)) begin
         perf_cnt <= perf_cnt + 32'd1;
      end
   end

   assign stall_cycles = perf_cnt;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

   logic clk = 1'b0;
   logic reset;
   logic load_use, md_start, mem_req, mem_ready, redirect;

   logic        stop_a, hold_a, flush_a, bubble_a, freeze_a, busy_a;
   logic [31:0] perf_a;
   logic        stop_b, hold_b, flush_b, bubble_b, freeze_b, busy_b;
   logic [31:0] perf_b;

   int checks = 0;
   int errors = 0;

`ifdef STALL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // {stop, ifid_hold, ifid_flush, idex_bubble, pipe_freeze, md_busy}
   localparam logic [5:0] O_IDLE  = 6'b000000;
   localparam logic [5:0] O_STALL = 6'b110010;
   localparam logic [5:0] O_LU    = 6'b110100;
   localparam logic [5:0] O_RD    = 6'b001100;
   localparam logic [5:0] O_MDS   = 6'b110011;
   localparam logic [5:0] O_MDR   = 6'b000001;

   logic [5:0] out_a, out_b;
   assign out_a = {stop_a, hold_a, flush_a, bubble_a, freeze_a, busy_a};
   assign out_b = {stop_b, hold_b, flush_b, bubble_b, freeze_b, busy_b};

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.MD_CYCLES(4), .CNT_W(6)) u_dut_a (
      .clk(clk), .reset(reset), .load_use(load_use), .md_start(md_start),
      .mem_req(mem_req), .mem_ready(mem_ready), .redirect(redirect),
      .stop(stop_a), .ifid_hold(hold_a), .ifid_flush(flush_a),
      .idex_bubble(bubble_a), .pipe_freeze(freeze_a), .md_busy(busy_a),
      .stall_cycles(perf_a)
   );

   pipe_stall_ctrl #(.MD_CYCLES(8), .CNT_W(6)) u_dut_b (
      .clk(clk), .reset(reset), .load_use(load_use), .md_start(md_start),
      .mem_req(mem_req), .mem_ready(mem_ready), .redirect(redirect),
      .stop(stop_b), .ifid_hold(hold_b), .ifid_flush(flush_b),
      .idex_bubble(bubble_b), .pipe_freeze(freeze_b), .md_busy(busy_b),
      .stall_cycles(perf_b)
   );

   task automatic drive(input logic lu, input logic md, input logic mr,
                        input logic rdy, input logic rd);
      load_use  = lu;
      md_start  = md;
      mem_req   = mr;
      mem_ready = rdy;
      redirect  = rd;
   endtask

   // Advance to the next cycle; inputs change 1ns after the posedge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (out_a !== O_IDLE) begin
         errors++;
         $display("FAIL reset_outputs_a: got %b expected %b", out_a, O_IDLE);
      end
      checks++;
      if (out_b !== O_IDLE) begin
         errors++;
         $display("FAIL reset_outputs_b: got %b expected %b", out_b, O_IDLE);
      end
      checks++;
      if (perf_a !== 32'd0) begin
         errors++;
         $display("FAIL reset_perf: got %0d expected 0", perf_a);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (out_a !== O_LU) begin
         errors++;
         $display("FAIL load_use_stall: got %b expected %b", out_a, O_LU);
      end
      tick();
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (out_a !== O_IDLE) begin
         errors++;
         $display("FAIL load_use_after: got %b expected %b", out_a, O_IDLE);
      end
      checks++;
      if (perf_a !== (PERF ? 32'd1 : 32'd0)) begin
         errors++;
         $display("FAIL load_use_perf: got %0d expected %0d", perf_a, PERF ? 1 : 0);
      end
      tick();
   endtask

   task automatic test_redirect_priority();
      do_reset();
      drive(1, 0, 0, 0, 1);
      @(negedge clk);
      checks++;
      if (out_a !== O_RD) begin
         errors++;
         $display("FAIL redirect_over_load_use: got %b expected %b", out_a, O_RD);
      end
      tick();
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (out_a !== O_IDLE) begin
         errors++;
         $display("FAIL redirect_after: got %b expected %b", out_a, O_IDLE);
      end
      tick();
   endtask

   // MD_CYCLES = 4: start cycle, 2 frozen, 1 release. Redirect/load_use held
   // throughout are ignored in MD_WAIT and honoured on the first RUN cycle.
   task automatic test_mult_div();
      logic [5:0] exp_seq [5];
      exp_seq[0] = O_STALL;
      exp_seq[1] = O_MDS;
      exp_seq[2] = O_MDS;
      exp_seq[3] = O_MDR;
      exp_seq[4] = O_RD;
      do_reset();
      drive(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (out_a !== exp_seq[i]) begin
            errors++;
            $display("FAIL mult_div_cycle%0d: got %b expected %b", i + 1, out_a, exp_seq[i]);
         end
         tick();
         drive(1, 0, 0, 0, 1);
      end
      checks++;
      if (perf_a !== (PERF ? 32'd3 : 32'd0)) begin
         errors++;
         $display("FAIL mult_div_perf: got %0d expected %0d", perf_a, PERF ? 3 : 0);
      end
      drive(0, 0, 0, 0, 0);
      tick();
   endtask

   // MD_CYCLES = 8 instance: reset asserted during cycle 5 (counter 3).
   task automatic test_reset_mid_md();
      do_reset();
      drive(0, 1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      tick();
      tick();
      tick();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (out_b !== O_MDS) begin
         errors++;
         $display("FAIL md_before_reset: got %b expected %b", out_b, O_MDS);
      end
      tick();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (out_b !== O_IDLE) begin
         errors++;
         $display("FAIL md_after_reset: got %b expected %b", out_b, O_IDLE);
      end
      checks++;
      if (perf_b !== 32'd0) begin
         errors++;
         $display("FAIL md_after_reset_perf: got %0d expected 0", perf_b);
      end
      tick();
      @(negedge clk);
      checks++;
      if (out_b !== O_IDLE) begin
         errors++;
         $display("FAIL md_reset_stays_run: got %b expected %b", out_b, O_IDLE);
      end
      tick();
   endtask

   // Ready arrives in cycle 4; redirect held throughout applies in cycle 5.
   task automatic test_mem_wait();
      logic [5:0] exp_seq [5];
      exp_seq[0] = O_STALL;
      exp_seq[1] = O_STALL;
      exp_seq[2] = O_STALL;
      exp_seq[3] = O_IDLE;
      exp_seq[4] = O_RD;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         if (i < 3)       drive(0, 0, 1, 0, 1);
         else if (i == 3) drive(0, 0, 1, 1, 1);
         else             drive(0, 0, 0, 0, 1);
         @(negedge clk);
         checks++;
         if (out_a !== exp_seq[i]) begin
            errors++;
            $display("FAIL mem_wait_cycle%0d: got %b expected %b", i + 1, out_a, exp_seq[i]);
         end
         tick();
      end
      checks++;
      if (perf_a !== (PERF ? 32'd3 : 32'd0)) begin
         errors++;
         $display("FAIL mem_wait_perf: got %0d expected %0d", perf_a, PERF ? 3 : 0);
      end
      drive(0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_mem_ready_same_cycle();
      do_reset();
      drive(1, 0, 1, 1, 0);
      @(negedge clk);
      checks++;
      if (out_a !== O_LU) begin
         errors++;
         $display("FAIL mem_ready_immediate: got %b expected %b", out_a, O_LU);
      end
      tick();
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (out_a !== O_IDLE) begin
         errors++;
         $display("FAIL mem_ready_immediate_after: got %b expected %b", out_a, O_IDLE);
      end
      tick();
   endtask

   task automatic test_mem_over_md();
      do_reset();
      drive(0, 1, 1, 0, 0);
      @(negedge clk);
      checks++;
      if (out_a !== O_STALL) begin
         errors++;
         $display("FAIL mem_over_md_c1: got %b expected %b", out_a, O_STALL);
      end
      tick();
      drive(0, 1, 1, 1, 0);
      @(negedge clk);
      checks++;
      if (out_a !== O_IDLE) begin
         errors++;
         $display("FAIL mem_over_md_release: got %b expected %b", out_a, O_IDLE);
      end
      tick();
      drive(0, 1, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (out_a !== O_STALL) begin
         errors++;
         $display("FAIL md_after_mem_start: got %b expected %b", out_a, O_STALL);
      end
      tick();
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (out_a !== O_MDS) begin
         errors++;
         $display("FAIL md_after_mem_busy: got %b expected %b", out_a, O_MDS);
      end
      tick();
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      test_reset();
      test_load_use();
      test_redirect_priority();
      test_mult_div();
      test_reset_mid_md();
      test_mem_wait();
      test_mem_ready_same_cycle();
      test_mem_over_md();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Hazard/stall sequencer for the pipelined MIPS core. Drives the PC register's `stop` input and the hold/flush/bubble controls of the IF/ID and ID/EX pipeline registers. Arbitrates among data-memory wait, multi-cycle mult/div occupancy, taken-branch/jump redirect and load-use hazards. Sits in the top-level processor between hazard detection, EX-stage branch resolution, the mult/div unit and the data-memory interface.

## Interface
Parameters:
- `MD_CYCLES`, 32, total EX occupancy of a mult/div op in cycles; legal range 2..2^CNT_W.
- `CNT_W`, 6, width of the mult/div down-counter.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `load_use` in 1: ID-stage load-use hazard detected.
- `md_start` in 1: mult/div instruction present in EX.
- `mem_req` in 1: MEM-stage load/store active.
- `mem_ready` in 1: data memory completes the access this cycle.
- `redirect` in 1: EX resolved a taken branch/jump; next PC is the target.
- `stop` out 1: PC hold; 1 = PC keeps its value.
- `ifid_hold` out 1: IF/ID keeps its contents.
- `ifid_flush` out 1: IF/ID loads a NOP.
- `idex_bubble` out 1: ID/EX loads a NOP.
- `pipe_freeze` out 1: ID/EX, EX/MEM and MEM/WB hold.
- `md_busy` out 1: mult/div sequencing in progress.
- `stall_cycles` out 32: performance counter (see Configuration).

## Operation
- States: RUN, MEM_WAIT, MD_WAIT. Reset → RUN, counter = 0.
- RUN, priority high→low:
  1. `mem_req && !mem_ready`: `stop`, `ifid_hold`, `pipe_freeze` = 1; next state MEM_WAIT.
  2. `md_start`: `stop`, `ifid_hold`, `pipe_freeze` = 1; counter ← MD_CYCLES−2; next state MD_WAIT.
  3. `redirect`: `ifid_flush` = 1, `idex_bubble` = 1, `stop` = 0 (PC loads target). Stay in RUN.
  4. `load_use`: `stop` = 1, `ifid_hold` = 1, `idex_bubble` = 1 for that cycle. Stay in RUN.
  5. Otherwise: all control outputs 0.
- Lower-priority requests in the same cycle are dropped, not queued. During a freeze the upstream stages hold, so `redirect` and `load_use` stay asserted and are re-evaluated on the first RUN cycle.
- MEM_WAIT:
  - `stop`, `ifid_hold`, `pipe_freeze` = 1 while `mem_ready` = 0.
  - In the cycle `mem_ready` = 1, all outputs are 0 and next state is RUN. All other inputs are ignored.
- MD_WAIT:
  - `md_busy` = 1. `stop`, `ifid_hold`, `pipe_freeze` = 1 while counter ≠ 0; counter decrements by one each cycle.
  - Counter = 0 is the release cycle: outputs 0, `md_busy` = 1, next state RUN.
  - `md_start`, `redirect`, `load_use` and memory inputs are ignored in MD_WAIT.
- `ifid_flush` and `ifid_hold` are never both 1. `ifid_flush`, `idex_bubble` and `pipe_freeze` are never 1 together.
- Encoding an unreachable state → RUN.

## Timing
- All outputs are combinational from (state, counter, inputs). No internal output registers.
- Reset values: state RUN, counter 0, `stall_cycles` 0. With all inputs 0, every output reads 0.
- `reset` is sampled at posedge and overrides all transitions, including mid-MD_WAIT and mid-MEM_WAIT. It returns to RUN and counter 0 on the following edge.
- Load-use costs exactly 1 stall cycle. Redirect costs 2 squashed slots (IF/ID and ID/EX) with 0 stall cycles.
- A mult/div occupies EX for exactly MD_CYCLES cycles: the `md_start` cycle, then MD_CYCLES−2 frozen cycles in MD_WAIT, then 1 release cycle.
- Memory wait stalls N cycles when `mem_ready` arrives N cycles after the request cycle. `mem_ready` = 1 in the request cycle causes 0 stall.

## Configuration
- `STALL_PERF_EN` defined:
  - `stall_cycles` increments by 1 on every posedge with `stop` = 1 and `reset` = 0.
  - Saturates at 0xFFFFFFFF.
  - Synchronous clear on `reset`.
- `STALL_PERF_EN` undefined: the counter is not built and `stall_cycles` is tied to 0.

## Test plan
- Reset mid-MD_WAIT: `md_start` then `reset` at cycle 5 → next cycle state RUN, `md_busy` = 0, `stop` = 0, `stall_cycles` = 0.
- Load-use pulse for 1 cycle → exactly one cycle with `stop` = `ifid_hold` = `idex_bubble` = 1. PC advances one cycle late.
- `redirect` and `load_use` both 1 → `ifid_flush` = `idex_bubble` = 1, `stop` = 0, `ifid_hold` = 0.
- MD_CYCLES = 4, `md_start` 1-cycle pulse → `stop` = 1 for 3 cycles, `md_busy` = 1 for 3 cycles, then RUN. With `STALL_PERF_EN`, `stall_cycles` = 3.
- `mem_req` = 1 with `mem_ready` low for 3 cycles, arriving in cycle 4 → `pipe_freeze`/`stop` = 1 in cycles 1–3, 0 in cycle 4. A `redirect` held through the wait is applied in cycle 5.
- `mem_req && !mem_ready` together with `md_start` → MEM_WAIT taken. `md_start` is honoured on the first RUN cycle after `mem_ready`.
